ata_req_sched: RTL and testbench

Request scheduler sitting in front of the disk controller's control-register slave port. Two requesters (kernel path, boot/DMA path) post sector-level read/write requests, and the block arbitrates between them round-robin. It then splits each request into chunks of at most 8 sectors (the controller's 4 KB buffer) and drives the controller's registers as a bus master: address, count, start, poll for done, clear done. Buffer movement is handed back to the owning requester through fill/drain handshakes between chunks.

---
 rtl/ata_req_sched_pkg.sv | 47 ++++
 rtl/ata_req_sched_if.sv | 22 ++
 rtl/ata_req_sched_rr_arb2.sv | 29 ++
 rtl/ata_req_sched.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_ata_req_sched.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ata_req_sched_pkg.sv
// Shared disk-controller definitions: register word map, control/status bit
// positions, scheduler state encoding and datapath widths.
package dsk_pkg;

    // Controller register word indices.
    localparam int unsigned WordCtl   = 0;
    localparam int unsigned WordCount = 1;
    localparam int unsigned WordLba   = 2;
    localparam int unsigned WordCap   = 3;

    // Word-0 bit positions (write: start/IEN/WRT/DONE, read: ERR/DONE/INIT).
    localparam int unsigned CtlStart = 0;
    localparam int unsigned CtlIen   = 1;
    localparam int unsigned CtlWrt   = 2;
    localparam int unsigned StsErr   = 3;
    localparam int unsigned CtlDone  = 4;
    localparam int unsigned StsInit  = 5;

    // Datapath widths.
    localparam int unsigned ChunkW = 4;   // chunk size 0..8
    localparam int unsigned CountW = 8;   // request sector count 0..255
    localparam int unsigned LbaW   = 28;
    localparam int unsigned AddrW  = 18;  // word address [19:2]

    typedef enum logic [3:0] {
        StInitRd,
        StInitGap,
        StCapRd,
        StIdle,
        StCheck,
        StWrLba,
        StWrCnt,
        StFill,
        StStart,
        StPoll,
        StPollGap,
        StClr,
        StDrain,
        StNext,
        StResp
    } sched_state_e;

    function automatic logic [AddrW-1:0] word_addr(input int unsigned w);
        return AddrW'(w);
    endfunction

endpackage

// File: rtl/ata_req_sched_if.sv
// Control-register bus between the scheduler (master) and the disk controller (slave).
interface ata_req_sched_if;
    import dsk_pkg::*;

    logic             m_en;
    logic             m_wr;
    logic [AddrW-1:0] m_addr;
    logic [31:0]      m_dout;
    logic [31:0]      m_din;
    logic             m_wait;

    modport master (
        output m_en, m_wr, m_addr, m_dout,
        input  m_din, m_wait
    );

    modport slave (
        input  m_en, m_wr, m_addr, m_dout,
        output m_din, m_wait
    );

endinterface

// File: rtl/ata_req_sched_rr_arb2.sv
// Two-input round-robin arbiter; under contention the requester not served last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    logic last_q;

    // Last-served owner; resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (update) begin
            last_q <= served;
        end
    end

    // Grant the sole requester, or the one not served last when both ask.
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (&req) ? ~last_q : req[1];
    end

endmodule

// File: rtl/ata_req_sched.sv
// Request scheduler: arbitrates two sector requesters, splits each request into
// controller-sized chunks and sequences the controller registers as bus master.
module ata_req_sched
    import dsk_pkg::*;
#(
    parameter int unsigned CHUNK_MAX = 8,
    parameter int unsigned POLL_GAP  = 16
) (
    input  logic              clk,
    input  logic              reset,
    ata_req_sched_if.master   bus,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_write,
    input  logic [55:0]       req_lba,
    input  logic [15:0]       req_count,
    output logic              owner,
    output logic [ChunkW-1:0] chunk_sectors,
    output logic              fill_req,
    input  logic              fill_ack,
    output logic              drain_req,
    input  logic              drain_ack,
    output logic [1:0]        done,
    output logic [1:0]        error,
    output logic              busy,
    output logic              disk_ready,
    output logic [31:0]       capacity
);

    localparam int unsigned       GapW      = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GapW-1:0]   GapLoad   = GapW'(POLL_GAP - 1);
    localparam logic [CountW-1:0] ChunkMaxC = CountW'(CHUNK_MAX);

    sched_state_e      state_q;
    logic [GapW-1:0]   gap_q;
    logic              m_en_q, m_wr_q;
    logic [AddrW-1:0]  m_addr_q;
    logic [31:0]       m_dout_q;
    logic [1:0]        req_ready_q, done_q, error_q;
    logic              owner_q, busy_q, ready_q, write_q, err_q;
    logic              fill_req_q, drain_req_q;
    logic [31:0]       cap_q;
    logic [LbaW-1:0]   lba_q;
    logic [CountW-1:0] rem_q;
    logic [ChunkW-1:0] chunk_q;

    logic              gnt_valid, gnt_idx, arb_update;
    logic [LbaW-1:0]   sel_lba;
    logic [CountW-1:0] sel_cnt;
    logic              sel_wr;
    logic [ChunkW-1:0] chunk_n;
    logic [32:0]       end_sum;
    logic              over_cap;
    logic [31:0]       start_word;

    assign arb_update = (state_q == StResp);

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .update    (arb_update),
        .served    (owner_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Winner's request fields, next chunk size, bounds check and start command word.
    always_comb begin
        sel_lba    = gnt_idx ? req_lba[55:28] : req_lba[27:0];
        sel_cnt    = gnt_idx ? req_count[15:8] : req_count[7:0];
        sel_wr     = req_write[gnt_idx];
        chunk_n    = (rem_q > ChunkMaxC) ? ChunkW'(ChunkMaxC) : ChunkW'(rem_q);
        end_sum    = {5'b0, lba_q} + {25'b0, rem_q};
        over_cap   = end_sum > {1'b0, cap_q};
        start_word = '0;
        start_word[CtlStart] = 1'b1;
        start_word[CtlWrt]   = write_q;
    end

    // Main sequencer: each bus state raises m_en once, holds it through m_wait,
    // and drops it on completion so consecutive transfers are always separated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StInitRd;
            gap_q       <= '0;
            m_en_q      <= 1'b0;
            m_wr_q      <= 1'b0;
            m_addr_q    <= '0;
            m_dout_q    <= '0;
            req_ready_q <= '0;
            done_q      <= '0;
            error_q     <= '0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            write_q     <= 1'b0;
            err_q       <= 1'b0;
            fill_req_q  <= 1'b0;
            drain_req_q <= 1'b0;
            cap_q       <= '0;
            lba_q       <= '0;
            rem_q       <= '0;
            chunk_q     <= '0;
        end else begin
            req_ready_q <= '0;
            done_q      <= '0;
            error_q     <= '0;
            unique case (state_q)
                StInitRd: begin
                    if (!m_en_q) begin
                        m_en_q   <= 1'b1;
                        m_wr_q   <= 1'b0;
                        m_addr_q <= word_addr(WordCtl);
                    end else if (!bus.m_wait) begin
                        m_en_q <= 1'b0;
                        if (bus.m_din[StsInit]) begin
                            state_q <= StCapRd;
                        end else begin
                            gap_q   <= GapLoad;
                            state_q <= StInitGap;
                        end
                    end
                end
                StInitGap: begin
                    if (gap_q == '0) begin
                        m_en_q   <= 1'b1;
                        m_wr_q   <= 1'b0;
                        m_addr_q <= word_addr(WordCtl);
                        state_q  <= StInitRd;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                StCapRd: begin
                    if (!m_en_q) begin
                        m_en_q   <= 1'b1;
                        m_wr_q   <= 1'b0;
                        m_addr_q <= word_addr(WordCap);
                    end else if (!bus.m_wait) begin
                        m_en_q  <= 1'b0;
                        cap_q   <= bus.m_din;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (gnt_valid) begin
                        owner_q     <= gnt_idx;
                        req_ready_q <= gnt_idx ? 2'b10 : 2'b01;
                        lba_q       <= sel_lba;
                        rem_q       <= sel_cnt;
                        write_q     <= sel_wr;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= StCheck;
                    end
                end
                StCheck: begin
                    if (rem_q == '0) begin
                        state_q <= StResp;
                    end else if (over_cap) begin
                        err_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        state_q <= StWrLba;
                    end
                end
                StWrLba: begin
                    if (!m_en_q) begin
                        m_en_q   <= 1'b1;
                        m_wr_q   <= 1'b1;
                        m_addr_q <= word_addr(WordLba);
                        m_dout_q <= {4'b0, lba_q};
                        chunk_q  <= chunk_n;
                    end else if (!bus.m_wait) begin
                        m_en_q  <= 1'b0;
                        state_q <= StWrCnt;
                    end
                end
                StWrCnt: begin
                    if (!m_en_q) begin
                        m_en_q   <= 1'b1;
                        m_wr_q   <= 1'b1;
                        m_addr_q <= word_addr(WordCount);
                        m_dout_q <= {28'b0, chunk_q};
                    end else if (!bus.m_wait) begin
                        m_en_q <= 1'b0;
                        if (write_q) begin
                            fill_req_q <= 1'b1;
                            state_q    <= StFill;
                        end else begin
                            state_q <= StStart;
                        end
                    end
                end
                StFill: begin
                    if (fill_ack) begin
                        fill_req_q <= 1'b0;
                        state_q    <= StStart;
                    end
                end
                StStart: begin
                    if (!m_en_q) begin
                        m_en_q   <= 1'b1;
                        m_wr_q   <= 1'b1;
                        m_addr_q <= word_addr(WordCtl);
                        m_dout_q <= start_word;
                    end else if (!bus.m_wait) begin
                        m_en_q  <= 1'b0;
                        state_q <= StPoll;
                    end
                end
                StPoll: begin
                    if (!m_en_q) begin
                        m_en_q   <= 1'b1;
                        m_wr_q   <= 1'b0;
                        m_addr_q <= word_addr(WordCtl);
                    end else if (!bus.m_wait) begin
                        m_en_q <= 1'b0;
                        if (bus.m_din[CtlDone]) begin
                            err_q   <= err_q | bus.m_din[StsErr];
                            state_q <= StClr;
                        end else begin
                            gap_q   <= GapLoad;
                            state_q <= StPollGap;
                        end
                    end
                end
                StPollGap: begin
                    if (gap_q == '0) begin
                        m_en_q   <= 1'b1;
                        m_wr_q   <= 1'b0;
                        m_addr_q <= word_addr(WordCtl);
                        state_q  <= StPoll;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                StClr: begin
                    if (!m_en_q) begin
                        m_en_q   <= 1'b1;
                        m_wr_q   <= 1'b1;
                        m_addr_q <= word_addr(WordCtl);
                        m_dout_q <= '0;
                    end else if (!bus.m_wait) begin
                        m_en_q <= 1'b0;
                        if (!write_q) begin
                            drain_req_q <= 1'b1;
                            state_q     <= StDrain;
                        end else begin
                            state_q <= StNext;
                        end
                    end
                end
                StDrain: begin
                    if (drain_ack) begin
                        drain_req_q <= 1'b0;
                        state_q     <= StNext;
                    end
                end
                StNext: begin
                    lba_q <= lba_q + LbaW'(chunk_q);
                    rem_q <= rem_q - CountW'(chunk_q);
                    if ((rem_q == CountW'(chunk_q)) || err_q) begin
                        state_q <= StResp;
                    end else begin
                        state_q <= StWrLba;
                    end
                end
                StResp: begin
                    done_q  <= owner_q ? 2'b10 : 2'b01;
                    error_q <= owner_q ? {err_q, 1'b0} : {1'b0, err_q};
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StInitRd;
            endcase
        end
    end

    assign bus.m_en      = m_en_q;
    assign bus.m_wr      = m_wr_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_dout    = m_dout_q;
    assign req_ready     = req_ready_q;
    assign owner         = owner_q;
    assign chunk_sectors = chunk_q;
    assign fill_req      = fill_req_q;
    assign drain_req     = drain_req_q;
    assign done          = done_q;
    assign error         = error_q;
    assign busy          = busy_q;
    assign disk_ready    = ready_q;
    assign capacity      = cap_q;

endmodule

// File: tb/tb_ata_req_sched.sv
// Directed bench for ata_req_sched with a behavioural controller and scoreboard.
module tb_ata_req_sched;
    import dsk_pkg::*;

    localparam logic [31:0] Cap = 32'h0001_0000;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid, req_ready, req_write, done, error;
    logic [55:0] req_lba;
    logic [15:0] req_count;
    logic        owner, fill_req, fill_ack, drain_req, drain_ack, busy, disk_ready;
    logic [3:0]  chunk_sectors;
    logic [31:0] capacity;

    ata_req_sched_if bus();

    ata_req_sched #(.CHUNK_MAX(8), .POLL_GAP(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_lba       (req_lba),
        .req_count     (req_count),
        .owner         (owner),
        .chunk_sectors (chunk_sectors),
        .fill_req      (fill_req),
        .fill_ack      (fill_ack),
        .drain_req     (drain_req),
        .drain_ack     (drain_ack),
        .done          (done),
        .error         (error),
        .busy          (busy),
        .disk_ready    (disk_ready),
        .capacity      (capacity)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [49:0] exp_wr[$];
    int          exp_grant[$];
    logic [3:0]  exp_done[$];

    // Controller model state.
    int          init_cnt, busy_cnt, start_cnt, stall_cnt, txn_cnt, cap_reads;
    logic        ctl_done, ctl_err, pend_err, init_flag;
    int          err_at = -1;
    logic [31:0] stall_lba = 32'hFFFF_FFFF;

    // Monitor state.
    int          fill_cnt = 0, drain_cnt = 0, fills_since_start = 0;
    int          done_seen = 0, ready_cyc = 0, done_cyc = 0;
    logic        fill_prev = 0, drain_prev = 0, stall_seen = 0;
    logic [49:0] stall_snap, e;
    int          g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign init_flag  = (init_cnt >= 40);
    assign bus.m_wait = bus.m_en && bus.m_wr && (bus.m_addr == 18'd2) &&
                        (bus.m_dout == stall_lba) && (stall_cnt < 5);

    always_comb begin
        bus.m_din = '0;
        case (bus.m_addr)
            18'd0:   bus.m_din = {26'b0, init_flag, ctl_done, ctl_err, 3'b0};
            18'd3:   bus.m_din = Cap;
            default: bus.m_din = '0;
        endcase
    end

    // Behavioural controller: INIT after 40 cycles, DONE 6 cycles after start.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt  <= 0;
            busy_cnt  <= 0;
            start_cnt <= 0;
            stall_cnt <= 0;
            txn_cnt   <= 0;
            cap_reads <= 0;
            ctl_done  <= 1'b0;
            ctl_err   <= 1'b0;
            pend_err  <= 1'b0;
        end else begin
            if (init_cnt < 1000) init_cnt <= init_cnt + 1;
            if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    ctl_done <= 1'b1;
                    ctl_err  <= pend_err;
                end
            end
            if (bus.m_en && bus.m_wait) stall_cnt <= stall_cnt + 1;
            if (bus.m_en && !bus.m_wait) begin
                txn_cnt <= txn_cnt + 1;
                if (!bus.m_wr && bus.m_addr == 18'd3) cap_reads <= cap_reads + 1;
                if (bus.m_wr && bus.m_addr == 18'd0) begin
                    if (bus.m_dout[0]) begin
                        busy_cnt  <= 6;
                        pend_err  <= (start_cnt == err_at);
                        start_cnt <= start_cnt + 1;
                    end else begin
                        ctl_done <= 1'b0;
                        ctl_err  <= 1'b0;
                    end
                end
            end
        end
    end

    // Requester-side buffer agent: ack one cycle after a request appears.
    always @(posedge clk) begin
        fill_ack  <= fill_req;
        drain_ack <= drain_req;
    end

    // Output monitor: bus writes, stall stability, grants and completions.
    always begin
        @(negedge clk);
        if (!reset) begin
            if (fill_req && !fill_prev) begin
                fill_cnt++;
                fills_since_start++;
            end
            if (drain_req && !drain_prev) drain_cnt++;
            fill_prev  = fill_req;
            drain_prev = drain_req;
            if (bus.m_en && !bus.m_wait && bus.m_wr) begin
                chk("wr_expected", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("bus_write", {bus.m_addr, bus.m_dout}, e);
                    if (bus.m_addr == 18'd0 && bus.m_dout[0]) begin
                        chk("fill_before_start", fills_since_start, bus.m_dout[2]);
                        fills_since_start = 0;
                    end
                end
            end
            if (bus.m_wait) begin
                if (!stall_seen) begin
                    stall_snap = {bus.m_addr, bus.m_dout};
                    stall_seen = 1'b1;
                end else begin
                    chk("stall_stable", {bus.m_en, bus.m_addr, bus.m_dout}, {1'b1, stall_snap});
                end
            end
            if (|req_ready) begin
                chk("grant_onehot", $onehot(req_ready), 1);
                chk("grant_expected", exp_grant.size() > 0, 1);
                if (exp_grant.size() > 0) begin
                    g = exp_grant.pop_front();
                    chk("grant_order", req_ready[1] ? 1 : 0, g);
                end
                ready_cyc = cyc;
            end
            if (|done) begin
                chk("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) chk("done_error", {error, done}, exp_done.pop_front());
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    // Scoreboard model: expected grant, register writes and completion for one request.
    task automatic push_req_exp(input int idx, input logic wr, input logic [31:0] lba,
                                input int cnt, input int err_chunk);
        logic [3:0]  d;
        logic [31:0] l;
        logic [32:0] sum;
        int          rem, n, c;
        logic        err;
        d   = '0;
        err = 1'b0;
        l   = lba;
        rem = cnt;
        c   = 0;
        sum = 33'(lba) + 33'(cnt);
        exp_grant.push_back(idx);
        if (cnt != 0 && sum > 33'(Cap)) begin
            err = 1'b1;
        end else begin
            while (rem > 0) begin
                n = (rem > 8) ? 8 : rem;
                exp_wr.push_back({18'd2, l});
                exp_wr.push_back({18'd1, 32'(n)});
                exp_wr.push_back({18'd0, wr ? 32'h5 : 32'h1});
                exp_wr.push_back({18'd0, 32'h0});
                if (c == err_chunk) begin
                    err = 1'b1;
                    break;
                end
                l   = l + 32'(n);
                rem = rem - n;
                c++;
            end
        end
        d[idx]     = 1'b1;
        d[2 + idx] = err;
        exp_done.push_back(d);
    endtask

    task automatic drive_req(input int idx, input logic wr, input logic [27:0] lba,
                             input logic [7:0] cnt);
        int t;
        req_write[idx]          = wr;
        req_lba[idx*28 +: 28]   = lba;
        req_count[idx*8 +: 8]   = cnt;
        req_valid[idx]          = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[idx] && t < 200);
        chk("req_accept", req_ready[idx], 1);
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_seen < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("done_count", done_seen, target);
    endtask

    int nd, t0, d0, f0, t;
    int kk[2];

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_lba   = '0;
        req_count = '0;
        #1 reset  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_en", bus.m_en, 0);
        chk("rst_m_wr", bus.m_wr, 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_m_dout", bus.m_dout, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_fill_drain", {fill_req, drain_req}, 0);
        chk("rst_done_error", {done, error}, 0);
        chk("rst_busy_ready", {busy, disk_ready}, 0);
        chk("rst_capacity", capacity, 0);
        chk("rst_owner_chunk", {owner, chunk_sectors}, 0);
        reset = 1'b0;

        // Init: INIT appears after 40 cycles, then a single capacity read.
        repeat (30) @(negedge clk);
        chk("init_not_ready_early", disk_ready, 0);
        t = 0;
        while (!disk_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("init_disk_ready", disk_ready, 1);
        chk("init_capacity", capacity, 32'h0001_0000);
        chk("init_cap_reads", cap_reads, 1);
        nd = 0;

        // Read of 20 sectors: chunks 8,8,4 with three drains.
        d0 = drain_cnt;
        push_req_exp(0, 1'b0, 32'h100, 20, -1);
        drive_req(0, 1'b0, 28'h100, 8'd20);
        nd++;
        wait_done(nd);
        chk("read_drains", drain_cnt - d0, 3);
        chk("read_not_busy", busy, 0);

        // Write of 3 sectors from requester 1: one fill, START word 0x5.
        f0 = fill_cnt;
        push_req_exp(1, 1'b1, 32'h200, 3, -1);
        drive_req(1, 1'b1, 28'h200, 8'd3);
        nd++;
        wait_done(nd);
        chk("write_fills", fill_cnt - f0, 1);

        // Contention: both requesters hold three requests each; expect 0,1,0,1,0,1.
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) push_req_exp(0, 1'b0, 32'h1000 + 32'(16 * (k / 2)), 1, -1);
            else            push_req_exp(1, 1'b1, 32'h2000 + 32'(16 * (k / 2)), 1, -1);
        end
        kk[0] = 0;
        kk[1] = 0;
        req_write      = 2'b10;
        req_lba[27:0]  = 28'h1000;
        req_lba[55:28] = 28'h2000;
        req_count      = 16'h0101;
        req_valid      = 2'b11;
        nd += 6;
        t = 0;
        while (done_seen < nd && t < 5000) begin
            @(negedge clk);
            t++;
            for (int i = 0; i < 2; i++) begin
                if (req_ready[i]) begin
                    kk[i]++;
                    if (kk[i] < 3) req_lba[i*28 +: 28] = (i == 1 ? 28'h2000 : 28'h1000) +
                                                         28'(16 * kk[i]);
                    else           req_valid[i] = 1'b0;
                end
            end
        end
        @(negedge clk);
        chk("contention_done", done_seen, nd);
        chk("contention_valid_dropped", req_valid, 0);

        // Out of range: 0xFFFF + 2 > capacity, no bus traffic, done 2 cycles after ready.
        t0 = txn_cnt;
        push_req_exp(0, 1'b0, 32'hFFFF, 2, -1);
        drive_req(0, 1'b0, 28'hFFFF, 8'd2);
        nd++;
        wait_done(nd);
        chk("bounds_no_traffic", txn_cnt - t0, 0);
        chk("bounds_latency", done_cyc - ready_cyc, 2);

        // Zero count: no error, no bus traffic.
        t0 = txn_cnt;
        push_req_exp(0, 1'b1, 32'h50, 0, -1);
        drive_req(0, 1'b1, 28'h50, 8'd0);
        nd++;
        wait_done(nd);
        chk("zero_no_traffic", txn_cnt - t0, 0);
        chk("zero_latency", done_cyc - ready_cyc, 2);

        // ERR on the first of three chunks stops the request.
        err_at = start_cnt;
        d0 = drain_cnt;
        push_req_exp(0, 1'b0, 32'h300, 20, 0);
        drive_req(0, 1'b0, 28'h300, 8'd20);
        nd++;
        wait_done(nd);
        chk("err_single_drain", drain_cnt - d0, 1);

        // Controller stalls the LBA write for five cycles.
        stall_lba = 32'h400;
        push_req_exp(1, 1'b1, 32'h400, 2, -1);
        drive_req(1, 1'b1, 28'h400, 8'd2);
        nd++;
        wait_done(nd);
        chk("stall_cycles", stall_cnt, 5);
        chk("stall_observed", stall_seen, 1);

        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("grant_queue_drained", exp_grant.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
